// File: rtl/histogram_derivative_stream.sv
// Streams d[i] = h[i] - h[i-1] from a histogram RAM through a 2-entry skid FIFO with valid/ready.
// Define HIST_DERIV_PEAK_EN to track the largest rising/falling edge and their bins.
module histogram_derivative_stream #(
    parameter int BINS    = 256,
    parameter int COUNT_W = 16,
    parameter int ADDR_W  = $clog2(BINS)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_rd_en,
    output logic [ADDR_W-1:0]  o_rd_addr,
    input  logic [COUNT_W-1:0] i_rd_data,
    output logic               o_deriv_valid,
    input  logic               i_deriv_ready,
    output logic [COUNT_W:0]   o_deriv,
    output logic [ADDR_W-1:0]  o_deriv_bin,
    output logic               o_deriv_last,
    output logic [COUNT_W:0]   o_max_deriv,
    output logic [ADDR_W-1:0]  o_max_bin,
    output logic [COUNT_W:0]   o_min_deriv,
    output logic [ADDR_W-1:0]  o_min_bin
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BINS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [COUNT_W:0]  deriv;
        logic [ADDR_W-1:0] bin;
        logic              last;
    } entry_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  addr;
    logic               rd_pend;
    logic [ADDR_W-1:0]  pend_bin;
    logic [COUNT_W-1:0] prev;
    entry_t             fifo [2];
    logic               wr_ptr, rd_ptr;
    logic [1:0]         count;
    logic [1:0]         occ_after;
    logic               start_ok, hs, room;
    entry_t             new_entry;

    assign start_ok = (state == IDLE) && i_start;
    assign hs       = o_deriv_valid && i_deriv_ready;

    // Credit check: entries left after this cycle's pop plus the read still in flight.
    assign occ_after = count + {1'b0, rd_pend} - {1'b0, hs};
    assign room      = occ_after < 2'd2;

    always_comb begin
        // NOTE: every output gets a default first, so no branch can infer a latch.
        state_nxt = state;
        o_rd_en   = 1'b0;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) state_nxt = RUN;
            end
            RUN: begin
                o_busy  = 1'b1;
                o_rd_en = room;
                if (room && addr == LAST_ADDR) state_nxt = DRAIN;
            end
            DRAIN: begin
                o_busy = 1'b1;
                if (hs && o_deriv_last) state_nxt = DONE;
            end
            DONE: begin
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_rd_addr = addr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: non-blocking throughout so every register samples pre-edge values.
        if (!i_rst_n) begin
            state    <= IDLE;
            addr     <= '0;
            rd_pend  <= 1'b0;
            pend_bin <= '0;
            prev     <= '0;
        end else begin
            state   <= state_nxt;
            rd_pend <= o_rd_en;
            if (start_ok) begin
                addr <= '0;
                prev <= '0;
            end else begin
                if (o_rd_en) begin
                    pend_bin <= addr;
                    if (addr != LAST_ADDR) addr <= addr + ADDR_W'(1);
                end
                if (rd_pend) prev <= i_rd_data;
            end
        end
    end

    always_comb begin
        new_entry.deriv = (pend_bin == '0) ? '0
                        : ({1'b0, i_rd_data} - {1'b0, prev});
        new_entry.bin   = pend_bin;
        new_entry.last  = (pend_bin == LAST_ADDR);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: the skid entries drive outputs directly, so they are reset; a deep RAM would not be.
        if (!i_rst_n) begin
            fifo[0] <= '0;
            fifo[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= '0;
        end else begin
            if (rd_pend) begin
                fifo[wr_ptr] <= new_entry;
                wr_ptr       <= ~wr_ptr;
            end
            if (hs) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, rd_pend} - {1'b0, hs};
        end
    end

    assign o_deriv_valid = (count != 2'd0);
    assign o_deriv       = fifo[rd_ptr].deriv;
    assign o_deriv_bin   = fifo[rd_ptr].bin;
    assign o_deriv_last  = fifo[rd_ptr].last;

`ifdef HIST_DERIV_PEAK_EN
    // Strict compares keep the lowest bin on ties; d[0] = 0 seeds both trackers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_max_deriv <= '0;
            o_max_bin   <= '0;
            o_min_deriv <= '0;
            o_min_bin   <= '0;
        end else if (start_ok) begin
            o_max_deriv <= '0;
            o_max_bin   <= '0;
            o_min_deriv <= '0;
            o_min_bin   <= '0;
        end else if (hs) begin
            if ($signed(o_deriv) > $signed(o_max_deriv)) begin
                o_max_deriv <= o_deriv;
                o_max_bin   <= o_deriv_bin;
            end
            if ($signed(o_deriv) < $signed(o_min_deriv)) begin
                o_min_deriv <= o_deriv;
                o_min_bin   <= o_deriv_bin;
            end
        end
    end
`else
    assign o_max_deriv = '0;
    assign o_max_bin   = '0;
    assign o_min_deriv = '0;
    assign o_min_bin   = '0;
`endif

endmodule

// File: doc/histogram_derivative_stream.md
Name: histogram_derivative_stream

Overview:
- Sequential, parametrised successor to the combinational histogram derivative.
- On a start pulse, reads BINS histogram bins serially from the histogram RAM and streams the signed first difference d[i] = h[i] - h[i-1] to a downstream consumer, with valid/ready backpressure.
- Optionally tracks the largest rising and falling edges and their bin indices. The star-detection threshold logic uses these to pick the background/star knee without re-scanning.

Parameters:
- BINS, 256, number of histogram bins; legal range 2 or more.
- COUNT_W, 16, width of one unsigned bin count.
- ADDR_W, $clog2(BINS), bin index width. Derived; must not be overridden.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  one-cycle start request; honoured only in IDLE.
- o_busy  out  1  high from the cycle after an accepted start until o_done.
- o_done  out  1  one-cycle pulse after the last derivative handshake.
- o_rd_en  out  1  histogram RAM read strobe.
- o_rd_addr  out  ADDR_W  histogram RAM read address.
- i_rd_data  in  COUNT_W  RAM data, valid exactly 1 cycle after o_rd_en.
- o_deriv_valid  out  1  derivative sample valid.
- i_deriv_ready  in  1  consumer ready.
- o_deriv  out  COUNT_W+1  signed two's-complement derivative.
- o_deriv_bin  out  ADDR_W  bin index i of o_deriv.
- o_deriv_last  out  1  high with the sample for bin BINS-1.
- o_max_deriv  out  COUNT_W+1  largest d[i] of the last completed scan.
- o_max_bin  out  ADDR_W  bin index of o_max_deriv.
- o_min_deriv  out  COUNT_W+1  smallest d[i] of the last completed scan.
- o_min_bin  out  ADDR_W  bin index of o_min_deriv.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, skid FIFO empty.
- Arithmetic:
  - d[0] = 0 (no predecessor).
  - d[i] = zero-extended h[i] minus zero-extended h[i-1], computed at COUNT_W+1 bits. The result never overflows.
  - h[i-1] is held in a register; each bin is read exactly once per scan.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on i_start. Read address counter cleared; previous-bin register cleared; peak trackers cleared.
  - RUN: o_rd_en is asserted with o_rd_addr = next address only when the 2-entry output skid FIFO has room for the in-flight read (occupancy + outstanding reads < 2). The address counter increments per issued read. After issuing address BINS-1, go to DRAIN.
  - DRAIN: no reads are issued. Go to DONE when the handshake for bin BINS-1 completes (o_deriv_valid & i_deriv_ready & o_deriv_last).
  - DONE: o_done = 1 for one cycle; o_busy falls in the same cycle; next state IDLE.
- Output stream:
  - Each returned bin produces one FIFO entry {d, i, last}.
  - o_deriv, o_deriv_bin and o_deriv_last hold stable while o_deriv_valid & !i_deriv_ready.
  - Samples appear in strict bin order, with no drops or duplicates under any ready pattern.
- Throughput and latency:
  - With i_deriv_ready tied high: one sample per cycle.
  - First o_deriv_valid appears 2 cycles after the first o_rd_en.
  - Scan completes in BINS+3 cycles from start to o_done.
- i_start while busy: ignored; no restart and no glitch on the stream.
- Reset mid-scan: aborts immediately. FIFO flushed, outputs zeroed, peaks zeroed; no o_done.
- BINS not a power of two: the address counter stops at BINS-1 and never wraps to out-of-range addresses.

Optional Feature:
- Macro: HIST_DERIV_PEAK_EN.
- Defined:
  - Peak trackers update on each output handshake, using signed compares.
  - Max updates only on strictly greater; min updates only on strictly smaller. Ties therefore keep the lowest bin.
  - Trackers start from d[0] = 0 at bin 0.
  - o_max_* and o_min_* are registered, and become final and valid in the o_done cycle.
  - They hold until the next accepted start, which clears them to 0.
- Undefined: no tracker logic is generated; o_max_deriv, o_max_bin, o_min_deriv and o_min_bin are tied to 0.

Test Plan:
- Ramp: BINS=256, h[i]=i, ready high -> 256 samples; d[0]=0 and d[1..255]=1; o_deriv_last only at bin 255; o_done at cycle 259 after start.
- Spike with peaks: h all 10 except h[40]=500 -> d[40]=+490, d[41]=-490. With HIST_DERIV_PEAK_EN: max=490/bin 40, min=-490/bin 41.
- Extremes: h[5]=65535, h[6]=0, all others 0 -> d[5]=+65535, d[6]=-65535 (17-bit 0x10001); no overflow.
- Backpressure: i_deriv_ready random at 30% duty -> stream identical to the ready-high run; o_rd_en never has more than 2 entries plus outstanding reads in flight; data stable while stalled.
- Control: i_start pulsed at cycles 3 and 50 of a scan -> ignored. i_rst_n dropped at bin 100 -> all outputs 0 asynchronously, no o_done. A fresh start then gives a correct full scan.
- Small and odd depth: BINS=2, then BINS=200 -> addresses 0..BINS-1 only, correct last flag; ties (flat h=7) -> max=min=0 at bin 0.
